// File: rtl/crc32_stream_checker.sv
// Receive-side CRC-32 frame checker: folds one byte per clock through an external
// byte-wise lookup table and reports residue, length and pass/fail once per frame.
module crc32_stream_checker #(
  parameter int unsigned LEN_W = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  output logic [7:0]       tab_addr,
  input  logic [31:0]      tab_rdata,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_ok,
  output logic             res_runt,
  output logic [LEN_W-1:0] res_len,
  output logic [31:0]      res_residue,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  localparam logic [31:0]      CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0]      CRC_GOOD = 32'hDEBB_20E3;
  localparam logic [LEN_W-1:0] LEN_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_REPORT} state_e;

  state_e           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             in_ready_q, in_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             res_ok_q, res_ok_d;
  logic             res_runt_q, res_runt_d;
  logic [LEN_W-1:0] res_len_q, res_len_d;
  logic [31:0]      res_residue_q, res_residue_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] bad_q, bad_d;
  logic [31:0]      base_c;
  logic [31:0]      crc_upd_c;
  logic             accept_c;

  // Start-of-frame substitutes the CRC seed so a restart never sees stale remainder.
  assign accept_c  = in_valid && in_ready_q;
  assign base_c    = in_sop ? CRC_INIT : crc_q;
  assign tab_addr  = base_c[7:0] ^ in_data;
  assign crc_upd_c = (base_c >> 8) ^ tab_rdata;

  assign in_ready    = in_ready_q;
  assign res_valid   = res_valid_q;
  assign res_ok      = res_ok_q;
  assign res_runt    = res_runt_q;
  assign res_len     = res_len_q;
  assign res_residue = res_residue_q;
  assign good_cnt    = good_q;
  assign bad_cnt     = bad_q;

  always_comb begin
    state_d       = state_q;
    crc_d         = crc_q;
    len_d         = len_q;
    res_ok_d      = res_ok_q;
    res_runt_d    = res_runt_q;
    res_len_d     = res_len_q;
    res_residue_d = res_residue_q;
    good_d        = good_q;
    bad_d         = bad_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c && in_sop) begin
          crc_d   = crc_upd_c;
          len_d   = LEN_W'(1);
          state_d = in_eop ? S_REPORT : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (accept_c) begin
          crc_d = crc_upd_c;
          if (in_sop) begin
            // Abandoned frame counts as bad; the sop byte begins the new frame.
            len_d = LEN_W'(1);
            bad_d = bad_q + CNT_W'(1);
          end else if (len_q != LEN_MAX) begin
            len_d = len_q + LEN_W'(1);
          end
          if (in_eop) state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          state_d = S_IDLE;
          if (res_ok_q) good_d = good_q + CNT_W'(1);
          else          bad_d  = bad_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Capture the result on the eop accept so fields hold steady through REPORT.
    if ((state_q != S_REPORT) && (state_d == S_REPORT)) begin
      res_len_d     = len_d;
      res_residue_d = crc_d;
      res_runt_d    = (len_d < LEN_W'(5));
      res_ok_d      = !(len_d < LEN_W'(5)) && (crc_d == CRC_GOOD);
    end

    in_ready_d  = (state_d != S_REPORT);
    res_valid_d = (state_d == S_REPORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      crc_q         <= CRC_INIT;
      len_q         <= '0;
      in_ready_q    <= 1'b1;
      res_valid_q   <= 1'b0;
      res_ok_q      <= 1'b0;
      res_runt_q    <= 1'b0;
      res_len_q     <= '0;
      res_residue_q <= '0;
      good_q        <= '0;
      bad_q         <= '0;
    end else begin
      state_q       <= state_d;
      crc_q         <= crc_d;
      len_q         <= len_d;
      in_ready_q    <= in_ready_d;
      res_valid_q   <= res_valid_d;
      res_ok_q      <= res_ok_d;
      res_runt_q    <= res_runt_d;
      res_len_q     <= res_len_d;
      res_residue_q <= res_residue_d;
      good_q        <= good_d;
      bad_q         <= bad_d;
    end
  end

endmodule

// File: tb/tb_crc32_stream_checker.sv
// Bench for crc32_stream_checker: frame-level CRC model plus directed frames, checked
// every cycle on a 16-bit-length instance and a 4-bit-length (saturating) instance.
module tb_crc32_stream_checker;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_sop, in_eop, res_ready;
  logic [7:0]  in_data;

  logic        in_ready, res_valid, res_ok, res_runt;
  logic [7:0]  tab_addr;
  logic [31:0] tab_rdata, res_residue;
  logic [15:0] res_len, good_cnt, bad_cnt;

  logic        s_in_ready, s_res_valid, s_res_ok, s_res_runt;
  logic [7:0]  s_tab_addr;
  logic [31:0] s_tab_rdata, s_res_residue;
  logic [3:0]  s_res_len;
  logic [15:0] s_good_cnt, s_bad_cnt;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] crc_tab(input logic [7:0] a);
    return crc_upd(32'h0, a);
  endfunction

  function automatic logic [31:0] crc_over(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (q[i]) c = crc_upd(c, q[i]);
    return c;
  endfunction

  assign tab_rdata   = crc_tab(tab_addr);
  assign s_tab_rdata = crc_tab(s_tab_addr);

  crc32_stream_checker #(.LEN_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .tab_addr(tab_addr), .tab_rdata(tab_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_ok(res_ok), .res_runt(res_runt),
    .res_len(res_len), .res_residue(res_residue), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  crc32_stream_checker #(.LEN_W(4), .CNT_W(16)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .tab_addr(s_tab_addr), .tab_rdata(s_tab_rdata),
    .res_valid(s_res_valid), .res_ready(res_ready), .res_ok(s_res_ok), .res_runt(s_res_runt),
    .res_len(s_res_len), .res_residue(s_res_residue), .good_cnt(s_good_cnt), .bad_cnt(s_bad_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: bytes of the open frame are folded with a bitwise CRC.
  bit          m_in = 1'b0, m_report = 1'b0;
  int          m_len = 0, m_good = 0, m_bad = 0;
  logic [31:0] m_crc = 32'hFFFF_FFFF;

  function automatic int sat_len(input int len, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (len > mx) ? mx : len;
  endfunction

  function automatic bit m_ok();
    return (m_len >= 5) && (m_crc == 32'hDEBB_20E3);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_in = 0; m_report = 0; m_good = 0; m_bad = 0; m_len = 0; m_crc = 32'hFFFF_FFFF;
    end else if (m_report) begin
      if (res_ready) begin
        if (m_ok()) m_good++; else m_bad++;
        m_report = 0;
      end
    end else if (in_valid) begin
      if (in_sop) begin
        if (m_in) m_bad++;
        m_in = 1; m_len = 1; m_crc = crc_upd(32'hFFFF_FFFF, in_data);
      end else if (m_in) begin
        m_len++; m_crc = crc_upd(m_crc, in_data);
      end
      if (m_in && in_eop) begin
        m_in = 0; m_report = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(!m_report));
      chk("res_valid", 32'(res_valid), 32'(m_report));
      chk("good_cnt", 32'(good_cnt), 32'(16'(m_good)));
      chk("bad_cnt", 32'(bad_cnt), 32'(16'(m_bad)));
      chk("sat_in_ready", 32'(s_in_ready), 32'(!m_report));
      chk("sat_res_valid", 32'(s_res_valid), 32'(m_report));
      chk("sat_good_cnt", 32'(s_good_cnt), 32'(16'(m_good)));
      chk("sat_bad_cnt", 32'(s_bad_cnt), 32'(16'(m_bad)));
      if (m_report) begin
        chk("res_len", 32'(res_len), 32'(sat_len(m_len, 16)));
        chk("res_residue", res_residue, m_crc);
        chk("res_runt", 32'(res_runt), 32'(m_len < 5));
        chk("res_ok", 32'(res_ok), 32'(m_ok()));
        chk("sat_res_len", 32'(s_res_len), 32'(sat_len(m_len, 4)));
        chk("sat_res_residue", s_res_residue, m_crc);
        chk("sat_res_ok", 32'(s_res_ok), 32'(m_ok()));
      end
      if (in_valid && !m_report && (in_sop || m_in)) begin
        chk("tab_addr", 32'(tab_addr), 32'((in_sop ? 8'hFF : m_crc[7:0]) ^ in_data));
        chk("sat_tab_addr", 32'(s_tab_addr), 32'((in_sop ? 8'hFF : m_crc[7:0]) ^ in_data));
      end
    end
  end

  // All driving happens 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input logic sop, input logic eop);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = b; in_sop = sop; in_eop = eop;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] q[$], input bit bubbles, input bit with_eop);
    foreach (q[i]) begin
      if (bubbles && $urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      send_byte(q[i], i == 0, with_eop && (i == q.size() - 1));
    end
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (!res_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!res_valid) chk("result_timeout", 32'(res_valid), 32'd1);
  endtask

  task automatic release_result(input int hold);
    idle(hold);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  logic [7:0] f1[$], fbad[$], frunt[$], fpart[$], fsat[$];
  logic [31:0] fcs;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'h00; res_ready = 1'b0;
    f1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    fbad = f1; fbad[2] = 8'h34;
    frunt = '{8'h61, 8'h62, 8'h63};
    fpart = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    for (int i = 0; i < 16; i++) fsat.push_back(8'(i));
    fcs = ~crc_over(fsat);
    for (int i = 0; i < 4; i++) fsat.push_back(fcs[8*i +: 8]);

    chk("model_T1", crc_tab(8'h01), 32'h7707_3096);
    chk("model_check_value", ~crc_over(f1[0:8]), 32'hCBF4_3926);

    repeat (3) @(posedge clk); #1;
    rst = 1'b0; chk_en = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_ok", 32'(res_ok), 32'd0);
    chk("rst_res_runt", 32'(res_runt), 32'd0);
    chk("rst_res_len", 32'(res_len), 32'd0);
    chk("rst_res_residue", res_residue, 32'd0);
    chk("rst_good_cnt", 32'(good_cnt), 32'd0);
    chk("rst_bad_cnt", 32'(bad_cnt), 32'd0);

    // Clean frame, back-to-back bytes; result must be up the cycle after eop.
    send_frame(f1, 1'b0, 1'b1);
    chk("clean_latency_valid", 32'(res_valid), 32'd1);
    chk("clean_len", 32'(res_len), 32'd13);
    chk("clean_residue", res_residue, 32'hDEBB_20E3);
    chk("clean_ok", 32'(res_ok), 32'd1);
    release_result(0);
    chk("clean_good_cnt", 32'(good_cnt), 32'd1);

    // Corrupted byte 3.
    send_frame(fbad, 1'b0, 1'b1);
    wait_result();
    chk("corrupt_ok", 32'(res_ok), 32'd0);
    chk("corrupt_runt", 32'(res_runt), 32'd0);
    release_result(1);
    chk("corrupt_bad_cnt", 32'(bad_cnt), 32'd1);
    chk("corrupt_good_cnt", 32'(good_cnt), 32'd1);

    // Stray byte without sop in IDLE is ignored.
    send_byte(8'h55, 1'b0, 1'b0);

    // Bubbles and a long-held result.
    send_frame(f1, 1'b1, 1'b1);
    wait_result();
    release_result(10);
    chk("bp_good_cnt", 32'(good_cnt), 32'd2);

    // Runt frame.
    send_frame(frunt, 1'b1, 1'b1);
    wait_result();
    chk("runt_len", 32'(res_len), 32'd3);
    chk("runt_flag", 32'(res_runt), 32'd1);
    chk("runt_ok", 32'(res_ok), 32'd0);
    release_result(2);

    // Restart: sop re-asserted on byte 6 starts a fresh good frame.
    send_frame(fpart, 1'b0, 1'b0);
    send_frame(f1, 1'b0, 1'b1);
    wait_result();
    chk("restart_ok", 32'(res_ok), 32'd1);
    release_result(0);
    chk("restart_bad_cnt", 32'(bad_cnt), 32'd3);
    chk("restart_good_cnt", 32'(good_cnt), 32'd3);

    // Single-byte sop+eop frame.
    send_byte(8'hA5, 1'b1, 1'b1);
    chk("single_len", 32'(res_len), 32'd1);
    chk("single_ok", 32'(res_ok), 32'd0);
    release_result(0);

    // Reset after 7 bytes of a frame.
    send_frame(f1[0:6], 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_good_cnt", 32'(good_cnt), 32'd0);
    chk("midrst_bad_cnt", 32'(bad_cnt), 32'd0);
    idle(2);
    send_frame(f1, 1'b0, 1'b1);
    chk("midrst_clean_len", 32'(res_len), 32'd13);
    release_result(0);
    chk("midrst_good_after", 32'(good_cnt), 32'd1);

    // 20-byte frame: the 4-bit length instance saturates but still passes.
    send_frame(fsat, 1'b0, 1'b1);
    chk("sat_len_lit", 32'(s_res_len), 32'd15);
    chk("sat_ok_lit", 32'(s_res_ok), 32'd1);
    chk("wide_len_lit", 32'(res_len), 32'd20);
    release_result(3);
    idle(3);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/crc32_stream_checker.md
# crc32_stream_checker

Receive-side CRC-32 checker: consumes a framed byte stream carrying a trailing 4-byte FCS and reports pass/fail per frame. It is the reader of the byte-wise CRC lookup table. It drives the table address each cycle and folds the combinational table word into its running remainder at one byte per clock. It sits between the link deframer and the packet buffer, and reports a result once per frame.

## Interface

Parameters:
- LEN_W, 16, width of the frame byte counter (saturating).
- CNT_W, 16, width of the good/bad frame statistics counters (wrapping).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  byte present on in_data.
- in_ready  output  1  checker can accept a byte.
- in_data  input  8  frame byte, FCS included, FCS least-significant byte first.
- in_sop  input  1  first byte of frame; qualified by in_valid.
- in_eop  input  1  last byte of frame (last FCS byte); qualified by in_valid.
- tab_addr  output  8  lookup index to CRC table.
- tab_rdata  input  32  table word, combinational in tab_addr.
- res_valid  output  1  frame result available.
- res_ready  input  1  result consumer accepts.
- res_ok  output  1  residue matched and frame not runt.
- res_runt  output  1  frame shorter than 5 bytes.
- res_len  output  LEN_W  bytes in frame including FCS, saturating at all-ones.
- res_residue  output  32  final remainder register, uninverted.
- good_cnt  output  CNT_W  frames reported with res_ok=1.
- bad_cnt  output  CNT_W  frames reported with res_ok=0, plus restarted frames.

## Operation

- Reflected CRC-32: init 0xFFFFFFFF, and the table holds T[i] for reflected polynomial 0xEDB88320.
- A byte is accepted when in_valid && in_ready.
- tab_addr = crc[7:0] ^ in_data, with crc replaced by 0xFFFFFFFF when in_sop.
- Update on accept: crc_next = (base >> 8) ^ tab_rdata. base = 0xFFFFFFFF if in_sop, else crc.
- Good frame: the residue after the last FCS byte equals 0xDEBB20E3.
- FSM states:
  - IDLE: in_ready=1. An accepted byte with in_sop goes to ACTIVE, or to REPORT if in_eop is also set. Bytes without in_sop are dropped with no state change and no counter effect.
  - ACTIVE: in_ready=1.
    - Accept without eop: stay.
    - Accept with eop: go to REPORT.
    - Accept with in_sop: the current frame is abandoned, bad_cnt increments, and the new frame starts from that byte.
  - REPORT: in_ready=0, res_valid=1.
    - Result fields are registered and stable.
    - On res_ready the state returns to IDLE, and good_cnt or bad_cnt increments in that same cycle.
- Length counter:
  - Loaded with 1 on an sop accept.
  - Otherwise increments per accept and saturates at 2^LEN_W-1.
- res_runt = (res_len < 5). res_ok = !res_runt && residue == 0xDEBB20E3.
- Statistics counters wrap.

## Timing

- Reset values:
  - Outputs: in_ready=1, res_valid=0, res_ok=0, res_runt=0, res_len=0, res_residue=0.
  - Counters: good_cnt=0, bad_cnt=0.
  - State: IDLE; internal crc=0xFFFFFFFF.
- Throughput: one byte per cycle, sustained, in IDLE/ACTIVE.
- Latency: eop accepted at cycle N, then res_valid=1 at N+1 with all result fields valid.
- Minimum frame spacing: the next sop can be accepted one cycle after the res_ready handshake, because in_ready rises in the cycle after the handshake.
- in_ready is registered (a function of state only) and never depends combinationally on in_valid.
- tab_addr is combinational from the crc register and in_data. The path in_data → tab_addr → tab_rdata → crc is single-cycle by design.
- rst asserted in any state, including mid-frame or with res_valid pending:
  - The state is IDLE next cycle.
  - The partial frame is discarded with no result and no counter increment.
  - Counters clear.
- An sop+eop single-byte frame is a runt: res_len=1, res_ok=0.

## Test plan

- Clean frame: ASCII "123456789" followed by 26 39 F4 CB, back-to-back valid → res_valid one cycle after eop, res_len=13, res_residue=0xDEBB20E3, res_ok=1, good_cnt=1.
- Corruption: same frame with byte 3 flipped to 0x34 → res_ok=0, res_runt=0, bad_cnt=1, good_cnt unchanged.
- Backpressure and gaps:
  - Random in_valid bubbles plus res_ready held low for 10 cycles.
  - Required: in_ready=0 throughout REPORT and result fields stable.
  - Required: a second good frame afterwards yields good_cnt=2.
- Runt and restart:
  - A 3-byte frame → res_len=3, res_runt=1, res_ok=0.
  - A frame with sop re-asserted at byte 6 → bad_cnt increments by 1, and the restarted good frame passes.
- Reset mid-frame: rst for one cycle after 7 bytes → no res_valid, counters 0; then a clean frame passes with res_len=13.
- Saturation: LEN_W=4 build, 20-byte frame → res_len=15, and res_ok reflects the residue only.
